alu16_reg: RTL and testbench

- 16-bit, 8-function arithmetic/logic unit with registered result and flags (zero, negative, carry).
- Single-cycle latency with a simple valid qualifier.
- Sits in the datapath as the shared ALU stage.
- Behavioural and structural datapath variants are selectable at compile time and must be bit-identical.

---
 rtl/alu16_reg.sv | 144 ++++++++++++++
 tb/tb_alu16_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu16_reg.sv
// Purpose : shared 8-function ALU stage with a registered result and zero/neg/carry flags.
// Latency : one cycle; the result launched with in_valid appears on w one clock later, with out_valid.
// Backpr. : none; in_valid may be asserted every cycle, and w/flags hold while in_valid is low.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  a/b/cin/func are valid; the result is captured on this clk edge
//   a, b      WIDTH-bit operands
//   cin       carry / borrow / shift-in bit
//   func      operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 ASR
//   w         registered result
//   zero      registered (w == 0)
//   neg       registered w[WIDTH-1]
//   cout      registered carry / borrow / shifted-out bit
//   out_valid high for one cycle after each accepted in_valid
//
// Build option: define ALU_STRUCTURAL_EN to build the datapath from a full-adder
// ripple chain, per-bit gates and an 8:1 mux tree. Without it, the datapath uses
// behavioural operators. Both builds are bit-identical.

`ifdef ALU_STRUCTURAL_EN
module alu16_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule
`endif

module alu16_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       func,
  output logic [WIDTH-1:0] w,
  output logic             zero,
  output logic             neg,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH-1:0] r;
  logic             c;

`ifdef ALU_STRUCTURAL_EN
  // One shared adder. SUB is a + ~b + ~cin, and the borrow is the inverted carry-out.
  logic [WIDTH-1:0] add_b;
  logic             add_ci;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] add_s;
  logic [WIDTH-1:0] and_r, or_r, xor_r, not_r;

  // func[0] separates SUB from ADD. The adder output is ignored for all other funcs.
  assign add_b    = func[0] ? ~b : b;
  assign add_ci   = func[0] ? ~cin : cin;
  assign carry[0] = add_ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    alu16_fa u_fa (
      .x  (a[i]),
      .y  (add_b[i]),
      .ci (carry[i]),
      .s  (add_s[i]),
      .co (carry[i+1])
    );
    assign and_r[i] = a[i] & b[i];
    assign or_r[i]  = a[i] | b[i];
    assign xor_r[i] = a[i] ^ b[i];
    assign not_r[i] = ~a[i];
  end

  // Each candidate is {carry, result}, so one tree selects both.
  logic [WIDTH:0] cand [8];
  logic [WIDTH:0] lvl1 [4];
  logic [WIDTH:0] lvl2 [2];

  assign cand[0] = {carry[WIDTH], add_s};
  assign cand[1] = {~carry[WIDTH], add_s};
  assign cand[2] = {1'b0, and_r};
  assign cand[3] = {1'b0, or_r};
  assign cand[4] = {1'b0, xor_r};
  assign cand[5] = {1'b0, not_r};
  assign cand[6] = {a[WIDTH-1], a[WIDTH-2:0], cin};
  assign cand[7] = {a[0], a[WIDTH-1], a[WIDTH-1:1]};

  for (genvar j = 0; j < 4; j++) begin : g_lvl1
    assign lvl1[j] = func[0] ? cand[2*j+1] : cand[2*j];
  end
  for (genvar k = 0; k < 2; k++) begin : g_lvl2
    assign lvl2[k] = func[1] ? lvl1[2*k+1] : lvl1[2*k];
  end
  assign {c, r} = func[2] ? lvl2[1] : lvl2[0];

`else
  always_comb begin
    r = '0;
    c = 1'b0;
    case (func)
      3'b000: {c, r} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      // A result below zero wraps modulo 2^(WIDTH+1), which sets the top bit: that bit is the borrow.
      3'b001: {c, r} = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = ~a;
      3'b110: {c, r} = {a, cin};
      3'b111: {r, c} = {a[WIDTH-1], a};
      default: begin
        r = '0;
        c = 1'b0;
      end
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w         <= '0;
      zero      <= 1'b1;
      neg       <= 1'b0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        w    <= r;
        zero <= (r == '0);
        neg  <= r[WIDTH-1];
        cout <= c;
      end
    end
  end

endmodule

// File: tb/tb_alu16_reg.sv
// Purpose : bench for alu16_reg (WIDTH=16), covering directed cases and a randomized sweep across every func.
// Latency : each result is checked 1 time unit after the clk edge that captures it.
// Backpr. : none; the bench drives in_valid directly.
module tb_alu16_reg;

  localparam int W = 16;
  localparam longint MODV = 64'd1 << W;
  localparam longint HALF = 64'd1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         cin;
  logic [2:0]   func;
  logic [W-1:0] w;
  logic         zero, neg, cout, out_valid;

  int checks = 0;
  int failures = 0;

  // Expected register state.
  logic [W-1:0] exp_w;
  logic         exp_z, exp_n, exp_c;

  alu16_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .func      (func),
    .w         (w),
    .zero      (zero),
    .neg       (neg),
    .cout      (cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model built from integer arithmetic. The return value is {carry, result}.
  function automatic logic [W:0] model(input longint av, input longint bv,
                                       input longint ci, input int f);
    longint res;
    longint car;
    res = 0;
    car = 0;
    case (f)
      0: begin
        res = av + bv + ci;
        car = (res >= MODV) ? 1 : 0;
        res = res % MODV;
      end
      1: begin
        res = av - bv - ci;
        car = (res < 0) ? 1 : 0;
        if (res < 0) res = res + MODV;
      end
      2: res = av & bv;
      3: res = av | bv;
      4: res = av ^ bv;
      5: res = (MODV - 1) - av;
      6: begin
        res = (av * 2 + ci) % MODV;
        car = (av >= HALF) ? 1 : 0;
      end
      default: begin
        res = av / 2 + ((av >= HALF) ? HALF : 0);
        car = av % 2;
      end
    endcase
    return {car[0], res[W-1:0]};
  endfunction

  task automatic check_all(input string tag, input logic exp_ov);
    check({tag, "_w"}, 32'(w), 32'(exp_w));
    check({tag, "_zero"}, 32'(zero), 32'(exp_z));
    check({tag, "_neg"}, 32'(neg), 32'(exp_n));
    check({tag, "_cout"}, 32'(cout), 32'(exp_c));
    check({tag, "_ovld"}, 32'(out_valid), 32'(exp_ov));
  endtask

  // Drive one operation, clock it in, update the expected state, then check every output.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic [2:0] f);
    logic [W:0] m;
    a        = av;
    b        = bv;
    cin      = ci;
    func     = f;
    in_valid = 1'b1;
    m        = model(longint'(av), longint'(bv), longint'(ci), int'(f));
    @(posedge clk);
    #1;
    exp_w = m[W-1:0];
    exp_c = m[W];
    exp_z = (m[W-1:0] == '0);
    exp_n = m[W-1];
    check_all(tag, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    func     = 3'b000;
    exp_w    = '0;
    exp_z    = 1'b1;
    exp_n    = 1'b0;
    exp_c    = 1'b0;
    #1;
    check_all("reset0", 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ADD
    do_op("add1", 16'h7FFF, 16'h0001, 1'b0, 3'b000);
    check("add1_const", 32'(w), 32'h8000);
    do_op("add2", 16'hFFFF, 16'h0000, 1'b1, 3'b000);
    check("add2_const", 32'({cout, zero, w}), 32'h30000);

    // SUB
    do_op("sub1", 16'h0005, 16'h0007, 1'b0, 3'b001);
    check("sub1_const", 32'({cout, neg, w}), 32'h3FFFE);
    do_op("sub2", 16'h0007, 16'h0005, 1'b1, 3'b001);
    check("sub2_const", 32'({cout, w}), 32'h00001);

    // Logic ops
    do_op("and", 16'hF0F0, 16'hFF00, 1'b1, 3'b010);
    check("and_const", 32'({cout, w}), 32'h0F000);
    do_op("or",  16'hF0F0, 16'hFF00, 1'b1, 3'b011);
    check("or_const", 32'({cout, w}), 32'h0FFF0);
    do_op("xor", 16'hF0F0, 16'hFF00, 1'b1, 3'b100);
    check("xor_const", 32'({cout, w}), 32'h00FF0);
    do_op("not", 16'hF0F0, 16'hFF00, 1'b1, 3'b101);
    check("not_const", 32'({cout, w}), 32'h00F0F);

    // Shifts
    do_op("shl", 16'h8001, 16'h1234, 1'b1, 3'b110);
    check("shl_const", 32'({cout, w}), 32'h10003);
    do_op("asr", 16'h8002, 16'h1234, 1'b1, 3'b111);
    check("asr_const", 32'({cout, neg, w}), 32'h1C001);

    // Hold for three idle cycles with new operands on the inputs.
    in_valid = 1'b0;
    a        = 16'h1111;
    b        = 16'h2222;
    func     = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all("hold", 1'b0);
    end

    // Assert reset mid-cycle while out_valid is high.
    do_op("pre_rst", 16'h1234, 16'h0001, 1'b0, 3'b000);
    #2 rst = 1'b1;
    #1;
    exp_w = '0;
    exp_z = 1'b1;
    exp_n = 1'b0;
    exp_c = 1'b0;
    check_all("rst_mid", 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_held", 1'b0);
    rst = 1'b0;
    do_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 3'b000);
    check("post_rst_const", 32'(w), 32'h0100);

    // Randomized sweep, 10 vectors per func, issued back to back.
    for (int i = 0; i < 80; i++) begin
      do_op("rand", W'($urandom), W'($urandom), 1'($urandom), 3'(i / 10));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all("tail", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
